// File: rtl/input_port_buffer_pkg.sv
// Shared NoC definitions: flit type codes, head-flit field offsets and the input-port FSM states.
package noc_pkg;

  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  localparam int DEST_LSB = 8;
  localparam int SRC_LSB  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  function automatic logic is_head(input logic [1:0] ftype);
    return (ftype == FLIT_HEAD) || (ftype == FLIT_SINGLE);
  endfunction

  function automatic logic is_tail(input logic [1:0] ftype);
    return (ftype == FLIT_TAIL) || (ftype == FLIT_SINGLE);
  endfunction

  function automatic logic is_orphan(input logic [1:0] ftype);
    return (ftype == FLIT_BODY) || (ftype == FLIT_TAIL);
  endfunction

endpackage

// File: rtl/input_port_buffer_if.sv
// Upstream link, route-computation and downstream link signals of one router input port.
interface input_port_buffer_if #(
  parameter int FLIT_W = 16,
  parameter int ADDR_W = 4
);

  logic              in_valid;
  logic [FLIT_W-1:0] in_flit;
  logic              in_ready;
  logic              rc_req;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dest_addr;
  logic              rc_valid;
  logic [3:0]        rc_port;
  logic              out_valid;
  logic [FLIT_W-1:0] out_flit;
  logic [3:0]        out_port;
  logic              out_ready;

  modport master (
    output in_valid, in_flit, rc_valid, rc_port, out_ready,
    input  in_ready, rc_req, src_addr, dest_addr, out_valid, out_flit, out_port
  );

  modport slave (
    input  in_valid, in_flit, rc_valid, rc_port, out_ready,
    output in_ready, rc_req, src_addr, dest_addr, out_valid, out_flit, out_port
  );

endinterface

// File: rtl/input_port_buffer_flit_fifo.sv
// First-word-fall-through flit FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module flit_fifo #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [FLIT_W-1:0] data_i,
  input  logic              pop_i,
  output logic [FLIT_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Head reads as zero when empty so stale storage never appears on the link.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/input_port_buffer.sv
// Router input port: buffers flits, decodes head flits, requests a route and streams the packet out.
// Optional packet/drop statistics are enabled with INPUT_PORT_BUFFER_STATS_EN.
module input_port_buffer
  import noc_pkg::*;
#(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input_port_buffer_if.slave        bus
`ifdef INPUT_PORT_BUFFER_STATS_EN
  ,
  output logic [7:0]                pkt_count,
  output logic [7:0]                drop_count
`endif
);

  state_e            state_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dest_q;
  logic [3:0]        port_q;

  logic [FLIT_W-1:0] head_flit;
  logic [1:0]        head_type;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop_send;
  logic              drop;

  flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (bus.in_flit),
    .pop_i   (pop_send || drop),
    .head_o  (head_flit),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign head_type = head_flit[FLIT_W-1 -: 2];

  // in_ready depends only on the registered count, so a same-cycle pop cannot open the door.
  assign bus.in_ready  = !fifo_full && rst_n;
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == ST_SEND) && !fifo_empty;
  assign pop_send      = bus.out_valid && bus.out_ready;
  assign drop          = (state_q == ST_IDLE) && !fifo_empty && is_orphan(head_type);

  assign bus.rc_req    = (state_q == ST_ROUTE);
  assign bus.src_addr  = src_q;
  assign bus.dest_addr = dest_q;
  assign bus.out_port  = port_q;
  assign bus.out_flit  = head_flit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dest_q  <= '0;
      port_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty && is_head(head_type)) begin
            dest_q  <= head_flit[DEST_LSB +: ADDR_W];
            src_q   <= head_flit[SRC_LSB +: ADDR_W];
            state_q <= ST_ROUTE;
          end
        end
        ST_ROUTE: begin
          if (bus.rc_valid) begin
            port_q  <= bus.rc_port;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (pop_send && is_tail(head_type)) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef INPUT_PORT_BUFFER_STATS_EN
  logic [7:0] pkt_q;
  logic [7:0] drop_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (pop_send && is_tail(head_type) && (pkt_q != 8'hFF)) begin
        pkt_q <= pkt_q + 8'd1;
      end
      if (drop && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;
`endif

endmodule
